// File: rtl/regfile_cp0_pkg.sv
// regfile_cp0_pkg: CP0 register map, field positions, exception codes and FSM states
package regfile_cp0_pkg;
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM7    = 15;
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_SW_LO  = 8;
  localparam int CA_SW_HI  = 9;
  localparam int CA_IP7    = 15;
  localparam logic [4:0] EXC_BREAK   = 5'b00001;
  localparam logic [4:0] EXC_SYSCALL = 5'b00011;
  localparam logic [4:0] EXC_OVF     = 5'b01100;
  localparam logic [4:0] EXC_UNDEF   = 5'b11111;
  typedef enum logic {ST_NORMAL = 1'b0, ST_EXC = 1'b1} exc_state_e;
endpackage

// File: rtl/regfile_cp0_unit_cp0_regs.sv
// cp0_regs: Count/Compare timer, Status, Cause, EPC, exception FSM and PC redirect
module cp0_regs
  import regfile_cp0_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h0000_0180,
  parameter int EXC_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [4:0]           i_raddr,
  output logic [DATA_W-1:0]    o_rdata,
  input  logic                 i_mtc0_en,
  input  logic [4:0]           i_mtc0_addr,
  input  logic [DATA_W-1:0]    i_mtc0_data,
  input  logic                 i_exc_valid,
  input  logic [4:0]           i_exc_code,
  input  logic [DATA_W-1:0]    i_exc_pc,
  input  logic                 i_eret,
  output logic                 o_redirect,
  output logic [DATA_W-1:0]    o_redirect_pc,
  output logic                 o_in_exception,
  output logic                 o_timer_irq,
  output logic [EXC_CNT_W-1:0] o_exc_count
);
  exc_state_e r_state, w_state_nxt;
  logic [DATA_W-1:0] r_count, r_compare, r_status, r_cause, r_epc;
  logic [DATA_W-1:0] w_status_base, w_cause_nxt;
  logic w_wr_count, w_wr_compare, w_wr_status, w_wr_cause, w_wr_epc, w_exl, w_eret_take;
  assign w_wr_count   = i_mtc0_en && i_mtc0_addr == CP0_COUNT;
  assign w_wr_compare = i_mtc0_en && i_mtc0_addr == CP0_COMPARE;
  assign w_wr_status  = i_mtc0_en && i_mtc0_addr == CP0_STATUS;
  assign w_wr_cause   = i_mtc0_en && i_mtc0_addr == CP0_CAUSE;
  assign w_wr_epc     = i_mtc0_en && i_mtc0_addr == CP0_EPC;
  assign w_exl        = r_state == ST_EXC;
  assign w_eret_take  = i_eret && w_exl && !i_exc_valid;
  // Exception beats eret, eret beats a software write of EXL
  always_comb begin
    w_state_nxt = i_exc_valid ? ST_EXC :
                  i_eret      ? ST_NORMAL :
                  w_wr_status ? exc_state_e'(i_mtc0_data[ST_EXL]) : r_state;
    w_status_base = w_wr_status ? i_mtc0_data : r_status;
    w_cause_nxt = '0;
    w_cause_nxt[CA_IP7] = w_wr_compare ? 1'b0 :
                          (r_count == r_compare && r_compare != '0) ? 1'b1 : r_cause[CA_IP7];
    w_cause_nxt[CA_EXC_HI:CA_EXC_LO] = i_exc_valid ? i_exc_code : r_cause[CA_EXC_HI:CA_EXC_LO];
    w_cause_nxt[CA_SW_HI:CA_SW_LO] = w_wr_cause ? i_mtc0_data[CA_SW_HI:CA_SW_LO] : r_cause[CA_SW_HI:CA_SW_LO];
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_NORMAL;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count       <= '0;
      r_compare     <= '0;
      r_status      <= '0;
      r_cause       <= '0;
      r_epc         <= '0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
      o_exc_count   <= '0;
    end else begin
      r_count       <= w_wr_count ? i_mtc0_data : r_count + DATA_W'(1);
      r_compare     <= w_wr_compare ? i_mtc0_data : r_compare;
      r_status      <= {w_status_base[DATA_W-1:ST_EXL+1], w_state_nxt == ST_EXC, w_status_base[ST_IE]};
      r_cause       <= w_cause_nxt;
      r_epc         <= (i_exc_valid && !w_exl) ? i_exc_pc : w_wr_epc ? i_mtc0_data : r_epc;
      o_redirect    <= i_exc_valid || w_eret_take;
      o_redirect_pc <= i_exc_valid ? EXC_VECTOR : w_eret_take ? r_epc : o_redirect_pc;
      o_exc_count   <= (i_exc_valid && o_exc_count != '1) ? o_exc_count + EXC_CNT_W'(1) : o_exc_count;
    end
  end
  assign o_rdata = i_raddr == CP0_COUNT   ? r_count :
                   i_raddr == CP0_COMPARE ? r_compare :
                   i_raddr == CP0_STATUS  ? r_status :
                   i_raddr == CP0_CAUSE   ? r_cause :
                   i_raddr == CP0_EPC     ? r_epc : '0;
  assign o_in_exception = w_exl;
  assign o_timer_irq = r_cause[CA_IP7] & r_status[ST_IM7] & r_status[ST_IE] & !w_exl;
endmodule

// File: rtl/regfile_cp0_unit.sv
// regfile_cp0_unit: 2R/1W GPR file with write-through bypass plus integrated CP0
module regfile_cp0_unit
  import regfile_cp0_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_ADDR_W = 5,
  parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h0000_0180,
  parameter int EXC_CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic [REG_ADDR_W-1:0] i_rt_addr,
  output logic [DATA_W-1:0]     o_rs_data,
  output logic [DATA_W-1:0]     o_rt_data,
  input  logic                  i_wr_en,
  input  logic [REG_ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic                  i_wb_is_nop,
  input  logic [4:0]            i_cp0_raddr,
  output logic [DATA_W-1:0]     o_cp0_rdata,
  input  logic                  i_mtc0_en,
  input  logic [4:0]            i_mtc0_addr,
  input  logic [DATA_W-1:0]     i_mtc0_data,
  input  logic                  i_exc_valid,
  input  logic [4:0]            i_exc_code,
  input  logic [DATA_W-1:0]     i_exc_pc,
  input  logic                  i_eret,
  output logic                  o_redirect,
  output logic [DATA_W-1:0]     o_redirect_pc,
  output logic                  o_in_exception,
  output logic                  o_timer_irq,
  output logic [EXC_CNT_W-1:0]  o_exc_count
);
  logic [DATA_W-1:0] r_gpr [2**REG_ADDR_W];
  logic w_we;
  // A faulting instruction never commits its result
  assign w_we = i_wr_en && i_wr_addr != '0 && !i_wb_is_nop && !i_exc_valid;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) for (int i = 0; i < 2**REG_ADDR_W; i++) r_gpr[i] <= '0;
    else if (w_we) r_gpr[i_wr_addr] <= i_wr_data;
  end
  assign o_rs_data = (w_we && i_wr_addr == i_rs_addr) ? i_wr_data : r_gpr[i_rs_addr];
  assign o_rt_data = (w_we && i_wr_addr == i_rt_addr) ? i_wr_data : r_gpr[i_rt_addr];
  cp0_regs #(.DATA_W(DATA_W), .EXC_VECTOR(EXC_VECTOR), .EXC_CNT_W(EXC_CNT_W)) u_cp0 (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_raddr(i_cp0_raddr),
    .o_rdata(o_cp0_rdata),
    .i_mtc0_en(i_mtc0_en),
    .i_mtc0_addr(i_mtc0_addr),
    .i_mtc0_data(i_mtc0_data),
    .i_exc_valid(i_exc_valid),
    .i_exc_code(i_exc_code),
    .i_exc_pc(i_exc_pc),
    .i_eret(i_eret),
    .o_redirect(o_redirect),
    .o_redirect_pc(o_redirect_pc),
    .o_in_exception(o_in_exception),
    .o_timer_irq(o_timer_irq),
    .o_exc_count(o_exc_count)
  );
endmodule

// File: doc/regfile_cp0_unit.md
Name: regfile_cp0_unit

Overview:
Parametrised successor to the pipeline's GPR file: a 2-read/1-write register file with write-through bypass, plus an integrated CP0 block. CP0 holds Count/Compare timer, Status, Cause and EPC, with a two-state exception FSM handling exception entry, nesting and ERET. It sits between ID (reads), WB (writes, exception reports) and the PC unit (redirect).

Parameters:
DATA_W, 32, width of GPRs and CP0 registers
REG_ADDR_W, 5, GPR address width; depth = 2**REG_ADDR_W
EXC_VECTOR, 32'h0000_0180, exception handler entry PC
EXC_CNT_W, 8, width of the saturating exception counter

Ports:
Clock  in  1  single clock; all state updates on posedge
Reset  in  1  asynchronous, active-high
rs_addr, rt_addr  in  REG_ADDR_W  read addresses
rs_data, rt_data  out  DATA_W  combinational read data
wr_en  in  1  GPR write request from WB
wr_addr  in  REG_ADDR_W  write address
wr_data  in  DATA_W  write data
wb_is_nop  in  1  WB slot holds a bubble; suppresses the write
cp0_raddr  in  5  MFC0 source register
cp0_rdata  out  DATA_W  combinational CP0 read data
mtc0_en  in  1  MTC0 write strobe
mtc0_addr  in  5  MTC0 destination
mtc0_data  in  DATA_W  MTC0 data
exc_valid  in  1  WB instruction raised an exception
exc_code  in  5  ExcCode (00001 break, 00011 syscall, 01100 overflow, 11111 undefined)
exc_pc  in  DATA_W  PC of the faulting instruction
eret  in  1  ERET retiring in WB
redirect  out  1  one-cycle pulse: PC must load redirect_pc
redirect_pc  out  DATA_W  target PC
in_exception  out  1  Status.EXL
timer_irq  out  1  masked timer interrupt request
exc_count  out  EXC_CNT_W  exceptions taken, saturating

Behaviour:
- Reset (async): all GPRs, Count, Compare, Status, Cause and EPC = 0; FSM in NORMAL; redirect = 0, redirect_pc = 0, exc_count = 0.
- GPR[0] reads 0 and is never written.
- GPR write at posedge when wr_en && wr_addr!=0 && !wb_is_nop && !exc_valid. A faulting instruction never commits.
- Read bypass: if a GPR write is qualifying this cycle and wr_addr==rs_addr (or rt_addr), output wr_data; otherwise output the array value. Zero latency.
- CP0 map (all other addresses read 0, writes ignored):
  - 9 Count: increments every cycle and wraps at 2**DATA_W; an MTC0 to Count loads mtc0_data instead of incrementing.
  - 11 Compare: an MTC0 here clears Cause.IP7.
  - 12 Status: bit0 IE, bit1 EXL, bits15:8 IM; fully writable.
  - 13 Cause: bits6:2 ExcCode, bit15 IP7; only bits9:8 are writable by MTC0.
  - 14 EPC: writable.
- Timer: when Count==Compare and Compare!=0, set Cause.IP7; it stays set until Compare is written. timer_irq = IP7 & IM7 & IE & !EXL.
- FSM states NORMAL (EXL=0) and EXC (EXL=1):
  - NORMAL + exc_valid: EPC<=exc_pc, ExcCode<=exc_code, EXL<=1, go to EXC. Next cycle redirect=1, redirect_pc=EXC_VECTOR.
  - EXC + exc_valid (nested): ExcCode updates, EPC is kept, stay in EXC. Next cycle redirect to EXC_VECTOR.
  - EXC + eret: EXL<=0, go to NORMAL. Next cycle redirect=1, redirect_pc=EPC value at eret.
  - NORMAL + eret: no state change, no redirect.
- exc_count increments on every accepted exc_valid and saturates at all-ones.
- Priorities in the same cycle:
  - exc_valid beats eret.
  - exc_valid beats an MTC0 to Status, Cause or EPC for the fields it updates; the MTC0 still applies to the other fields.
  - An MTC0 to Status.EXL in the same cycle as eret: eret wins.
- redirect is high for exactly one cycle per event. Events on back-to-back cycles give back-to-back pulses.
- Reset asserted mid-exception returns to NORMAL immediately and drops redirect.

Decomposition:
- Package regfile_cp0_pkg holds:
  - CP0 address constants (CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14)
  - Status/Cause bit-position constants
  - ExcCode constants
  - the FSM state enum.
- One sub-module, cp0_regs, contains the Count/Compare/Status/Cause/EPC registers, the FSM and the redirect logic. The top level holds the GPR array and the bypass logic.

Test Plan:
1. Write GPR5=0xDEADBEEF with rs_addr=5 in the same cycle -> rs_data=0xDEADBEEF that cycle; write to GPR0 -> reads 0; wb_is_nop=1 -> no write.
2. exc_valid with code 01100, exc_pc=0x40 and wr_en to GPR3 -> GPR3 unchanged, EPC=0x40, Cause[6:2]=01100, next cycle redirect=1 with redirect_pc=0x180, in_exception=1.
3. Nested: second exc_valid (code 00011, pc=0x184) while EXL=1 -> EPC stays 0x40, ExcCode=00011, redirect to 0x180. Then eret -> redirect_pc=0x40, in_exception=0, exc_count=2.
4. MTC0 Compare=20, Status=0x8001 -> timer_irq rises on the cycle after Count reaches 20. Writing Compare again -> timer_irq falls.
5. exc_valid and eret in the same cycle while in EXC -> exception is taken, redirect to 0x180, EXL stays 1. eret in NORMAL -> no redirect.
6. Assert Reset while in EXC with a redirect pending -> all outputs 0 asynchronously. After release, Count restarts from 0.
